load_extend_stage: RTL and testbench
====================================

# load_extend_stage

Registered load-data alignment and extension stage between data-memory read data and the writeback mux of the pipeline. Selects the addressed byte/half/word lane from a DATA_W-wide memory word, sign- or zero-extends it to DATA_W, and flags misaligned accesses. It generalises the fixed 16-to-32 sign extender to any lane size, either signedness and parametrised width. It carries a valid/ready handshake with a 2-entry skid buffer so a writeback stall never drops data.

## Interface
- DATA_W, 32: memory word and result width; 32 or 64.
- OFS_W, localparam = log2(DATA_W/8): byte-offset width.
- clk  input  1  rising-edge clock.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  load request valid.
- in_ready  output  1  stage can accept a request this cycle.
- in_rdata  input  DATA_W  raw memory word, byte 0 in bits [7:0] (little-endian lanes).
- in_ofs  input  OFS_W  byte offset of the load address.
- in_size  input  2  0 byte, 1 half, 2 word, 3 dword; dword legal only when DATA_W=64.
- in_signed  input  1  1 sign-extend, 0 zero-extend.
- out_valid  output  1  result valid.
- out_ready  input  1  writeback accepts the result.
- out_data  output  DATA_W  extended result.
- out_misaligned  output  1  result came from a misaligned or illegal-size request.

## Operation
- Lane width L = 8<<in_size; lane = in_rdata[in_ofs*8 +: L]; upper DATA_W-L bits = in_signed ? lane[L-1] replicated : 0. L=DATA_W passes the word through unchanged.
- Misaligned when in_ofs mod (L/8) != 0; illegal when in_size=3 and DATA_W=32. Both set out_misaligned.
- Extension is computed combinationally on the input side; only extended data plus flag are stored.
- Buffer states: EMPTY (nothing held), ONE (main register valid), TWO (main + skid valid).
- in_ready = (state != TWO); out_valid = (state != EMPTY); outputs always driven from main register.
- Accept = in_valid & in_ready; drain = out_valid & out_ready.
- EMPTY: accept -> ONE (load main).
- ONE: accept & drain -> ONE (main reloaded); accept only -> TWO (load skid); drain only -> EMPTY.
- TWO: drain -> ONE (skid moves to main); no drain -> TWO, input held off.
- in_ready depends only on registered state, never combinationally on out_ready.
- Simultaneous accept and drain in ONE: new data visible on out_data next cycle, no bubble.

## Timing
- Latency: accepted request appears on out_data exactly 1 cycle later when buffer empty.
- Throughput: 1 result/cycle while out_ready held high.
- Reset (any cycle, including mid-transfer): state EMPTY, out_valid=0, out_data=0, out_misaligned=0, skid contents cleared; in_ready=0 while rst high, 1 from the first clock after deassertion.
- out_data/out_misaligned stable while out_valid=1 and out_ready=0.
- Requests in flight at reset are discarded; no partial result is ever presented.

## Configuration
- LOAD_EXT_MISALIGN_TRAP_EN defined: misaligned/illegal requests produce out_data=0 and out_misaligned=1 (handshake unchanged; trap logic downstream).
- Undefined: in_ofs is rounded down to the lane alignment (low bits masked), normal extended data produced, out_misaligned tied 0.

## Structure
- Shared package: size encodings (SZ_BYTE=0, SZ_HALF=1, SZ_WORD=2, SZ_DWORD=3) and the buffer state encoding, reused by the store-lane unit.
- One sub-module: lane_extend, purely combinational lane select + extension + misalign detect, instanced once on the input side; the top holds the state machine and registers.

## Test plan
- DATA_W=32, rdata=0x80FF7F01, ofs=1, size=0, signed=1 -> out_data=0x0000007F; ofs=2 signed=1 -> 0xFFFFFFFF; ofs=3 signed=0 -> 0x00000080, each 1 cycle after accept.
- rdata=0x8001_1234, ofs=2, size=1: signed -> 0xFFFF8001, unsigned -> 0x00008001; size=2 ofs=0 -> 0x80011234.
- ofs=1, size=1 with TRAP_EN -> out_data=0, out_misaligned=1; without -> treated as ofs=0, out_data=0x00001234, flag 0.
- Back-to-back 8 requests, out_ready low for cycles 3-5 -> in_ready drops after 2 held, all 8 results emerge in order, none lost or duplicated.
- rst asserted while state TWO -> next cycle out_valid=0, out_data=0; first post-reset request returns correctly with 1-cycle latency.
- DATA_W=64: size=3 ofs=0 passes word; size=2 ofs=4 rdata=0x8000_0000_0000_0000 signed -> 0xFFFFFFFF80000000.

Source files
------------

// File: rtl/load_extend_stage_pkg.sv
// Shared encodings for the load/store lane units: access sizes and skid-buffer states.
// Used by load_extend_stage (optional LOAD_EXT_MISALIGN_TRAP_EN build) and the store-lane unit.
package load_extend_stage_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE  = 2'd0,
        SZ_HALF  = 2'd1,
        SZ_WORD  = 2'd2,
        SZ_DWORD = 2'd3
    } size_e;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } buf_state_e;

endpackage

// File: rtl/load_extend_stage_lane_extend.sv
// Combinational lane select, sign/zero extension and misalignment detection.
// LOAD_EXT_MISALIGN_TRAP_EN defined: bad accesses yield zero data plus flag; otherwise offset is rounded down.
module lane_extend
    import load_extend_stage_pkg::*;
#(
    parameter int DATA_W = 32,
    localparam int OFS_W = $clog2(DATA_W / 8)
) (
    input  logic [DATA_W-1:0] rdata,
    input  logic [OFS_W-1:0]  ofs,
    input  logic [1:0]        size,
    input  logic              sign_ext,
    output logic [DATA_W-1:0] data,
    output logic              misaligned
);

    logic [OFS_W-1:0]  ofs_mask_s;
    logic [6:0]        lane_bits_s;
    logic [OFS_W-1:0]  aligned_ofs_s;
    logic [DATA_W-1:0] shifted_s;
    logic [DATA_W-1:0] val_mask_s;
    logic              sign_bit_s;
    logic              fill_s;
    logic [DATA_W-1:0] ext_s;

    // Decode access size into byte-offset mask and lane width in bits
    always_comb begin
        ofs_mask_s  = '0;
        lane_bits_s = 7'd8;
        case (size_e'(size))
            SZ_BYTE: begin
                ofs_mask_s  = OFS_W'(3'd0);
                lane_bits_s = 7'd8;
            end
            SZ_HALF: begin
                ofs_mask_s  = OFS_W'(3'd1);
                lane_bits_s = 7'd16;
            end
            SZ_WORD: begin
                ofs_mask_s  = OFS_W'(3'd3);
                lane_bits_s = 7'd32;
            end
            SZ_DWORD: begin
                ofs_mask_s  = OFS_W'(3'd7);
                lane_bits_s = 7'd64;
            end
            default: begin
                ofs_mask_s  = '0;
                lane_bits_s = 7'd8;
            end
        endcase
    end

    assign aligned_ofs_s = ofs & ~ofs_mask_s;
    assign shifted_s     = rdata >> {aligned_ofs_s, 3'b000};
    // A shift by the full word width yields zero, so a full-width lane gets an all-ones mask
    assign val_mask_s    = ~({DATA_W{1'b1}} << lane_bits_s);

    // Pick the lane's top bit as the sign source
    always_comb begin
        sign_bit_s = 1'b0;
        case (size_e'(size))
            SZ_BYTE:  sign_bit_s = shifted_s[7];
            SZ_HALF:  sign_bit_s = shifted_s[15];
            SZ_WORD:  sign_bit_s = shifted_s[31];
            SZ_DWORD: sign_bit_s = shifted_s[DATA_W-1];
            default:  sign_bit_s = 1'b0;
        endcase
    end

    assign fill_s = sign_ext & sign_bit_s;
    assign ext_s  = (shifted_s & val_mask_s) | ({DATA_W{fill_s}} & ~val_mask_s);

`ifdef LOAD_EXT_MISALIGN_TRAP_EN
    logic illegal_s;
    logic bad_s;

    assign illegal_s = (size_e'(size) == SZ_DWORD) && (DATA_W < 64);
    assign bad_s     = illegal_s | ((ofs & ofs_mask_s) != '0);

    // Suppress data of a trapping access so nothing stale reaches writeback
    always_comb begin
        data       = ext_s;
        misaligned = bad_s;
        if (bad_s) begin
            data = '0;
        end else begin
            data = ext_s;
        end
    end
`else
    assign data       = ext_s;
    assign misaligned = 1'b0;
`endif

endmodule

// File: rtl/load_extend_stage.sv
// Registered load alignment/extension stage with a 2-entry skid buffer on the output handshake.
// Optional build macro LOAD_EXT_MISALIGN_TRAP_EN (see lane_extend).
module load_extend_stage
    import load_extend_stage_pkg::*;
#(
    parameter int DATA_W = 32,
    localparam int OFS_W = $clog2(DATA_W / 8)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_rdata,
    input  logic [OFS_W-1:0]  in_ofs,
    input  logic [1:0]        in_size,
    input  logic              in_signed,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_misaligned
);

    buf_state_e        state_r;
    buf_state_e        state_next_s;
    logic              ready_r;
    logic              valid_r;
    logic [DATA_W-1:0] main_data_r;
    logic              main_mis_r;
    logic [DATA_W-1:0] skid_data_r;
    logic              skid_mis_r;
    logic [DATA_W-1:0] ext_data_s;
    logic              ext_mis_s;
    logic              accept_s;
    logic              drain_s;
    logic              load_main_in_s;
    logic              load_main_skid_s;
    logic              load_skid_s;

    lane_extend #(
        .DATA_W (DATA_W)
    ) u_lane_extend (
        .rdata      (in_rdata),
        .ofs        (in_ofs),
        .size       (in_size),
        .sign_ext   (in_signed),
        .data       (ext_data_s),
        .misaligned (ext_mis_s)
    );

    // ready/valid are registered mirrors of the state, so in_ready never sees out_ready
    assign accept_s = in_valid & ready_r;
    assign drain_s  = valid_r & out_ready;

    // Next-state and register-load decode
    always_comb begin
        state_next_s     = state_r;
        load_main_in_s   = 1'b0;
        load_main_skid_s = 1'b0;
        load_skid_s      = 1'b0;
        case (state_r)
            ST_EMPTY: begin
                if (accept_s) begin
                    state_next_s   = ST_ONE;
                    load_main_in_s = 1'b1;
                end else begin
                    state_next_s = ST_EMPTY;
                end
            end
            ST_ONE: begin
                if (accept_s && drain_s) begin
                    state_next_s   = ST_ONE;
                    load_main_in_s = 1'b1;
                end else if (accept_s) begin
                    state_next_s = ST_TWO;
                    load_skid_s  = 1'b1;
                end else if (drain_s) begin
                    state_next_s = ST_EMPTY;
                end else begin
                    state_next_s = ST_ONE;
                end
            end
            ST_TWO: begin
                if (drain_s) begin
                    state_next_s     = ST_ONE;
                    load_main_skid_s = 1'b1;
                end else begin
                    state_next_s = ST_TWO;
                end
            end
            default: begin
                state_next_s = ST_EMPTY;
            end
        endcase
    end

    // State register with handshake flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_EMPTY;
            ready_r <= 1'b0;
            valid_r <= 1'b0;
        end else begin
            state_r <= state_next_s;
            ready_r <= (state_next_s != ST_TWO);
            valid_r <= (state_next_s != ST_EMPTY);
        end
    end

    // Main and skid data registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_data_r <= '0;
            main_mis_r  <= 1'b0;
            skid_data_r <= '0;
            skid_mis_r  <= 1'b0;
        end else begin
            if (load_main_in_s) begin
                main_data_r <= ext_data_s;
                main_mis_r  <= ext_mis_s;
            end else if (load_main_skid_s) begin
                main_data_r <= skid_data_r;
                main_mis_r  <= skid_mis_r;
            end
            if (load_skid_s) begin
                skid_data_r <= ext_data_s;
                skid_mis_r  <= ext_mis_s;
            end
        end
    end

    assign in_ready       = ready_r;
    assign out_valid      = valid_r;
    assign out_data       = main_data_r;
    assign out_misaligned = main_mis_r;

endmodule

// File: tb/tb_load_extend_stage.sv
// Directed bench for load_extend_stage: 32-bit and 64-bit instances, expectations adapt to LOAD_EXT_MISALIGN_TRAP_EN.
module tb_load_extend_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        in_valid_32 = 1'b0;
    logic        in_ready_32;
    logic [31:0] in_rdata_32 = 32'h0;
    logic [1:0]  in_ofs_32 = 2'd0;
    logic [1:0]  in_size_32 = 2'd0;
    logic        in_signed_32 = 1'b0;
    logic        out_valid_32;
    logic        out_ready_32 = 1'b1;
    logic [31:0] out_data_32;
    logic        out_mis_32;

    logic        in_valid_64 = 1'b0;
    logic        in_ready_64;
    logic [63:0] in_rdata_64 = 64'h0;
    logic [2:0]  in_ofs_64 = 3'd0;
    logic [1:0]  in_size_64 = 2'd0;
    logic        in_signed_64 = 1'b0;
    logic        out_valid_64;
    logic        out_ready_64 = 1'b1;
    logic [63:0] out_data_64;
    logic        out_mis_64;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    load_extend_stage #(.DATA_W(32)) u_dut32 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid_32), .in_ready(in_ready_32), .in_rdata(in_rdata_32),
        .in_ofs(in_ofs_32), .in_size(in_size_32), .in_signed(in_signed_32),
        .out_valid(out_valid_32), .out_ready(out_ready_32),
        .out_data(out_data_32), .out_misaligned(out_mis_32)
    );

    load_extend_stage #(.DATA_W(64)) u_dut64 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid_64), .in_ready(in_ready_64), .in_rdata(in_rdata_64),
        .in_ofs(in_ofs_64), .in_size(in_size_64), .in_signed(in_signed_64),
        .out_valid(out_valid_64), .out_ready(out_ready_64),
        .out_data(out_data_64), .out_misaligned(out_mis_64)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic req32(input string tag, input logic [31:0] rd, input logic [1:0] ofs,
                         input logic [1:0] sz, input logic sg, input logic [31:0] exp,
                         input logic exp_mis);
        @(negedge clk);
        in_valid_32  = 1'b1;
        in_rdata_32  = rd;
        in_ofs_32    = ofs;
        in_size_32   = sz;
        in_signed_32 = sg;
        out_ready_32 = 1'b1;
        check({tag, "_rdy"}, 64'(in_ready_32), 64'd1);
        @(negedge clk);
        in_valid_32 = 1'b0;
        check({tag, "_vld"}, 64'(out_valid_32), 64'd1);
        check(tag, 64'(out_data_32), 64'(exp));
        check({tag, "_mis"}, 64'(out_mis_32), 64'(exp_mis));
    endtask

    task automatic req64(input string tag, input logic [63:0] rd, input logic [2:0] ofs,
                         input logic [1:0] sz, input logic sg, input logic [63:0] exp);
        @(negedge clk);
        in_valid_64  = 1'b1;
        in_rdata_64  = rd;
        in_ofs_64    = ofs;
        in_size_64   = sz;
        in_signed_64 = sg;
        out_ready_64 = 1'b1;
        @(negedge clk);
        in_valid_64 = 1'b0;
        check({tag, "_vld"}, 64'(out_valid_64), 64'd1);
        check(tag, out_data_64, exp);
        check({tag, "_mis"}, 64'(out_mis_64), 64'd0);
    endtask

    initial begin
        logic [31:0] exp_q [8];
        int          sent;
        int          got;
        logic        rdy_c4;

        // Reset state
        @(negedge clk);
        check("rst_rdy", 64'(in_ready_32), 64'd0);
        check("rst_vld", 64'(out_valid_32), 64'd0);
        check("rst_data", 64'(out_data_32), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_rdy", 64'(in_ready_32), 64'd1);

        // Byte, half, word extraction
        req32("b_ofs1_s", 32'h80FF7F01, 2'd1, 2'd0, 1'b1, 32'h0000007F, 1'b0);
        req32("b_ofs2_s", 32'h80FF7F01, 2'd2, 2'd0, 1'b1, 32'hFFFFFFFF, 1'b0);
        req32("b_ofs3_u", 32'h80FF7F01, 2'd3, 2'd0, 1'b0, 32'h00000080, 1'b0);
        req32("b_ofs3_s", 32'h80FF7F01, 2'd3, 2'd0, 1'b1, 32'hFFFFFF80, 1'b0);
        req32("h_ofs2_s", 32'h80011234, 2'd2, 2'd1, 1'b1, 32'hFFFF8001, 1'b0);
        req32("h_ofs2_u", 32'h80011234, 2'd2, 2'd1, 1'b0, 32'h00008001, 1'b0);
        req32("w_ofs0",   32'h80011234, 2'd0, 2'd2, 1'b1, 32'h80011234, 1'b0);

        // Misaligned accesses
`ifdef LOAD_EXT_MISALIGN_TRAP_EN
        req32("h_ofs1_mis", 32'h80011234, 2'd1, 2'd1, 1'b1, 32'h00000000, 1'b1);
        req32("w_ofs2_mis", 32'h80011234, 2'd2, 2'd2, 1'b1, 32'h00000000, 1'b1);
        req32("d_illegal",  32'h80011234, 2'd0, 2'd3, 1'b1, 32'h00000000, 1'b1);
`else
        req32("h_ofs1_mis", 32'h80011234, 2'd1, 2'd1, 1'b1, 32'h00001234, 1'b0);
        req32("w_ofs2_mis", 32'h80011234, 2'd2, 2'd2, 1'b1, 32'h80011234, 1'b0);
        req32("h_ofs3_mis", 32'h80011234, 2'd3, 2'd1, 1'b1, 32'hFFFF8001, 1'b0);
`endif

        // Back-to-back stream with a three-cycle writeback stall
        for (int i = 0; i < 8; i++) begin
            exp_q[i] = 32'hC0DE0000 | 32'(i * 17);
        end
        sent   = 0;
        got    = 0;
        rdy_c4 = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            in_valid_32  = (sent < 8);
            in_rdata_32  = (sent < 8) ? exp_q[sent] : 32'h0;
            in_ofs_32    = 2'd0;
            in_size_32   = 2'd2;
            in_signed_32 = 1'b0;
            out_ready_32 = !(c >= 3 && c <= 5);
            if (c == 4) begin
                rdy_c4 = in_ready_32;
            end
            if (out_valid_32 && out_ready_32) begin
                if (got < 8) begin
                    check($sformatf("stream_%0d", got), 64'(out_data_32), 64'(exp_q[got]));
                end
                got++;
            end
            if (in_valid_32 && in_ready_32) begin
                sent++;
            end
            if (got >= 8 && sent >= 8) begin
                break;
            end
        end
        @(negedge clk);
        in_valid_32  = 1'b0;
        out_ready_32 = 1'b1;
        check("stream_stall_rdy", 64'(rdy_c4), 64'd0);
        check("stream_sent", 64'(sent), 64'd8);
        check("stream_got", 64'(got), 64'd8);
        check("stream_empty", 64'(out_valid_32), 64'd0);

        // Reset while both buffer entries are full
        out_ready_32 = 1'b0;
        in_valid_32  = 1'b1;
        in_size_32   = 2'd2;
        in_rdata_32  = 32'hAAAA5555;
        @(negedge clk);
        in_rdata_32 = 32'h5555AAAA;
        @(negedge clk);
        in_valid_32 = 1'b0;
        check("two_full_rdy", 64'(in_ready_32), 64'd0);
        check("two_full_data", 64'(out_data_32), 64'h00000000AAAA5555);
        rst = 1'b1;
        #1;
        check("mid_rst_vld", 64'(out_valid_32), 64'd0);
        check("mid_rst_data", 64'(out_data_32), 64'd0);
        @(negedge clk);
        check("mid_rst_rdy", 64'(in_ready_32), 64'd0);
        rst = 1'b0;
        out_ready_32 = 1'b1;
        @(negedge clk);
        check("after_rst_rdy", 64'(in_ready_32), 64'd1);
        check("after_rst_vld", 64'(out_valid_32), 64'd0);
        req32("after_rst_req", 32'h12345678, 2'd2, 2'd1, 1'b0, 32'h00001234, 1'b0);

        // 64-bit instance
        req64("d64_pass", 64'h0123456789ABCDEF, 3'd0, 2'd3, 1'b1, 64'h0123456789ABCDEF);
        req64("w64_ofs4_s", 64'h8000000000000000, 3'd4, 2'd2, 1'b1, 64'hFFFFFFFF80000000);
        req64("w64_ofs4_u", 64'h8000000000000000, 3'd4, 2'd2, 1'b0, 64'h0000000080000000);
        req64("b64_ofs7_s", 64'h8000000000000000, 3'd7, 2'd0, 1'b1, 64'hFFFFFFFFFFFFFF80);
        req64("h64_ofs6_u", 64'hBEEF000000000000, 3'd6, 2'd1, 1'b0, 64'h000000000000BEEF);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
